// File: rtl/tnkiii_linebuf_ctrl_if.sv
// Sprite-engine -> line buffer controller handshake bundle.
// The master is the sprite fetch engine; the slave is tnkiii_linebuf_ctrl.
// A run command (cmd_*) opens a run. Pixels (pix_*) then fill it one per consumed beat.
interface tnkiii_linebuf_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_x;
  logic [4:0]        cmd_len;
  logic              pix_valid;
  logic              pix_ready;
  logic [7:0]        pix_data;

  modport master (
    output cmd_valid, cmd_x, cmd_len, pix_valid, pix_data,
    input  cmd_ready, pix_ready
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_len, pix_valid, pix_data,
    output cmd_ready, pix_ready
  );
endinterface

// File: rtl/tnkiii_linebuf_ctrl.sv
// Ping-pong sprite line buffer sequencer for two 512x8 sync-read bank RAMs.
// - Draw bank: a two-state write FSM takes sprite runs and writes the
//   opaque pixels.
// - Scan bank: it is read once per cen_pix. The controller registers the
//   read data into lbuf_out two clocks after the address goes out.
// - Banks swap on every hld pulse.
// Build option LBUF_CLEAR_EN: when defined, each scanned address is rewritten
// with CLEAR_VAL on the clock after it is read. When undefined, the scan bank
// is never written. Read timing is the same in both builds.
module tnkiii_linebuf_ctrl #(
  parameter int                ADDR_W    = 9,
  parameter logic [2:0]        TRANSP    = 3'b111,
  parameter logic [7:0]        CLEAR_VAL = 8'hFF,
  parameter logic [ADDR_W-1:0] FLIP_OFS  = 199
) (
  input  logic                     clk,
  input  logic                     VIDEO_RSTn,
  input  logic                     cen_pix,
  input  logic                     hld,
  input  logic                     flip,
  input  logic [ADDR_W-1:0]        rd_start,
  tnkiii_linebuf_ctrl_if.slave     spr,
  output logic [ADDR_W-1:0]        l0_addr,
  output logic                     l0_we,
  output logic [7:0]               l0_din,
  input  logic [7:0]               l0_dout,
  output logic [ADDR_W-1:0]        l1_addr,
  output logic                     l1_we,
  output logic [7:0]               l1_din,
  input  logic [7:0]               l1_dout,
  output logic                     bank_sel,
  output logic [7:0]               lbuf_out,
  output logic                     overrun
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  typedef enum logic {
    S_IDLE,
    S_DRAW
  } wr_state_t;

  wr_state_t         state, state_nxt;
  logic [ADDR_W-1:0] wa, wa_nxt;       // draw-side write address
  logic [4:0]        remain, remain_nxt; // pixels left in the run, 1..16
  logic              alive;            // low only until the first clock after reset
  logic              draw_we;
  logic              ovr_set;

  logic [ADDR_W-1:0] ra;               // scan-side read address
  logic              rd_dn;            // scan direction latched at line start
  logic              clr_pend;         // previous clock presented a scan read
  logic [ADDR_W-1:0] clr_addr;         // address read on that clock
  logic              pend_bank;        // bank that read targeted
  logic              clr_now;
  logic              scan_we;
  logic [ADDR_W-1:0] scan_addr;
  logic [7:0]        scan_din;
  logic [7:0]        draw_din;

  // Write FSM state and run bookkeeping registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge VIDEO_RSTn) begin
    if (!VIDEO_RSTn) begin
      state  <= S_IDLE;
      wa     <= '0;
      remain <= '0;
    end else begin
      state  <= state_nxt;
      wa     <= wa_nxt;
      remain <= remain_nxt;
    end
  end

  // Write FSM next state, handshake and draw-bank write strobe.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt     = state;
    wa_nxt        = wa;
    remain_nxt    = remain;
    spr.cmd_ready = 1'b0;
    spr.pix_ready = 1'b0;
    draw_we       = 1'b0;
    ovr_set       = 1'b0;
    case (state)
      S_IDLE: begin
        // A line-start pulse blocks acceptance so no run straddles a swap.
        spr.cmd_ready = alive & ~hld;
        if (alive && !hld && spr.cmd_valid) begin
          wa_nxt     = spr.cmd_x;
          remain_nxt = (spr.cmd_len == 5'd0) ? 5'd16 : spr.cmd_len;
          state_nxt  = S_DRAW;
        end
      end
      S_DRAW: begin
        if (hld) begin
          // Line ended before the run finished: abandon it, flag it.
          state_nxt = S_IDLE;
          ovr_set   = 1'b1;
        end else begin
          spr.pix_ready = 1'b1;
          if (spr.pix_valid) begin
            draw_we    = (spr.pix_data[2:0] != TRANSP);
            wa_nxt     = wa + ADDR_ONE;
            remain_nxt = remain - 5'd1;
            if (remain == 5'd1) state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bank swap, sticky overrun flag and post-reset ready qualifier.
  always_ff @(posedge clk or negedge VIDEO_RSTn) begin
    if (!VIDEO_RSTn) begin
      bank_sel <= 1'b0;
      overrun  <= 1'b0;
      alive    <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (hld)     bank_sel <= ~bank_sel;
      if (ovr_set) overrun  <= 1'b1;
    end
  end

  // Read counter: load at line start, then step once per pixel enable.
  always_ff @(posedge clk or negedge VIDEO_RSTn) begin
    if (!VIDEO_RSTn) begin
      ra    <= '0;
      rd_dn <= 1'b0;
    end else if (hld) begin
      ra    <= flip ? (rd_start - FLIP_OFS) : rd_start;
      rd_dn <= flip;
    end else if (cen_pix) begin
      ra <= rd_dn ? (ra - ADDR_ONE) : (ra + ADDR_ONE);
    end
  end

  // Remember each scan read for the clear slot and the output capture.
  always_ff @(posedge clk or negedge VIDEO_RSTn) begin
    if (!VIDEO_RSTn) begin
      clr_pend  <= 1'b0;
      clr_addr  <= '0;
      pend_bank <= 1'b0;
    end else begin
      clr_pend <= cen_pix;
      if (cen_pix) begin
        clr_addr  <= ra;
        pend_bank <= ~bank_sel;
      end
    end
  end

  // Register the scan-bank read data one clock after it became valid.
  always_ff @(posedge clk or negedge VIDEO_RSTn) begin
    if (!VIDEO_RSTn) begin
      lbuf_out <= CLEAR_VAL;
    end else if (clr_pend) begin
      lbuf_out <= pend_bank ? l1_dout : l0_dout;
    end
  end

  // Scan-bank bus: read address, or the clear-behind-reader slot.
  // The clear is dropped if a swap has since handed that bank to the drawer.
  always_comb begin
    clr_now   = clr_pend & (pend_bank == ~bank_sel);
    scan_addr = clr_now ? clr_addr : ra;
`ifdef LBUF_CLEAR_EN
    scan_we   = clr_now;
`else
    scan_we   = 1'b0;
`endif
    scan_din  = scan_we ? CLEAR_VAL : 8'h00;
    draw_din  = draw_we ? spr.pix_data : 8'h00;
  end

  // Route the draw and scan buses to the physical banks.
  always_comb begin
    if (!bank_sel) begin
      l0_addr = wa;
      l0_we   = draw_we;
      l0_din  = draw_din;
      l1_addr = scan_addr;
      l1_we   = scan_we;
      l1_din  = scan_din;
    end else begin
      l0_addr = scan_addr;
      l0_we   = scan_we;
      l0_din  = scan_din;
      l1_addr = wa;
      l1_we   = draw_we;
      l1_din  = draw_din;
    end
  end

endmodule
